dbus_ctrl: RTL and testbench
============================

DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 Parameters, one per line, SHALL be:
- DATA_WIDTH, 32, data and address width
- TIMEOUT, 64, maximum cycles to wait for a bus response
REQ-002 Ports, one per line, SHALL be:
- clk, input, 1, sole clock, rising edge
- rst, input, 1, synchronous active-high reset
- req_valid, input, 1, mem stage has a load/store this cycle
- req_we, input, 1, 1=store, 0=load
- req_addr, input, DATA_WIDTH, byte address from LSU
- req_wdata, input, DATA_WIDTH, pre-shifted store data
- req_mask, input, DATA_WIDTH/8, byte enables
- stall_req, output, 1, freezes pipeline while a transaction is pending
- resp_valid, output, 1, one-cycle pulse: transaction complete
- resp_rdata, output, DATA_WIDTH, load data to LSU (mem_data_in)
- resp_err, output, 1, bus error or timeout, valid with resp_valid
- bus_req_valid, output, 1, bus request valid
- bus_req_ready, input, 1, bus accepts request
- bus_we, bus_addr, bus_wdata, bus_mask, outputs, 1/DATA_WIDTH/DATA_WIDTH/DATA_WIDTH/8, registered request fields
- bus_rsp_valid, input, 1, bus response valid
- bus_rsp_data, input, DATA_WIDTH, bus read data
- bus_rsp_err, input, 1, bus error flag
REQ-003 The block SHALL use one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, REQ, RESP, DONE; at most one transaction outstanding.
REQ-005 IDLE: req_valid=1 -> capture we/mask/wdata, bus_addr={req_addr[DW-1:2],2'b00}; go to REQ next cycle.
REQ-006 stall_req SHALL equal (state==IDLE & req_valid) | state==REQ | state==RESP; it SHALL be 0 in DONE.
REQ-007 REQ: bus_req_valid=1 with stable fields until bus_req_ready=1; on handshake go to RESP.
REQ-008 RESP: timeout counter increments each cycle from 0; bus_rsp_valid=1 -> latch rdata (loads only; stores latch 0) and err, go to DONE.
REQ-009 RESP: counter reaching TIMEOUT-1 without bus_rsp_valid -> DONE with resp_err=1, resp_rdata=0.
REQ-010 bus_rsp_valid and timeout in the same cycle: response wins, resp_err=bus_rsp_err.
REQ-011 DONE: resp_valid=1 for exactly one cycle; resp_rdata/resp_err held from latch; req_valid ignored (it is the same, now-retiring instruction); next state IDLE.
REQ-012 resp_rdata and resp_err SHALL hold their last values outside DONE.
REQ-013 bus_rsp_valid in IDLE, REQ or DONE (stray/late response) SHALL be ignored, with no state change.
REQ-014 Minimum latency: req_valid at cycle N, ready at N+1, rsp at N+2 -> resp_valid at N+3.
REQ-015 Back-to-back: a new req_valid in the IDLE cycle after DONE SHALL start a new transaction.
REQ-016 bus_req_valid SHALL never be asserted outside REQ; the request SHALL not be withdrawn before ready.

Reset
REQ-017 rst=1 at a clock edge -> state IDLE, counter 0, bus_req_valid=0, resp_valid=0, resp_err=0, resp_rdata=0, bus_we/addr/wdata/mask=0.
REQ-018 rst mid-transaction (REQ or RESP) SHALL abort; a response arriving afterwards is ignored per REQ-013.

Verification
REQ-019 Load, addr=0x0000_1006, mask=4'b0100; ready immediate, rsp 1 cycle later with data 0xAABB_CCDD -> bus_addr=0x0000_1004, resp_valid at N+3, resp_rdata=0xAABB_CCDD, err=0.
REQ-020 Store, wdata=0x1234_5678, mask=4'hF; ready held 0 for 3 cycles -> bus fields stable 3 cycles, bus_we=1, stall_req high until DONE, resp_rdata=0.
REQ-021 TIMEOUT=4, no response -> resp_valid 4 cycles after entering RESP, resp_err=1, resp_rdata=0; late rsp ignored.
REQ-022 bus_rsp_err=1 with data 0xDEAD_BEEF -> resp_err=1, resp_rdata=0xDEAD_BEEF.
REQ-023 rst asserted in RESP -> IDLE next cycle, bus_req_valid=0, stall_req=0 (req_valid=0), following rsp ignored.
REQ-024 Two back-to-back loads -> two separate bus handshakes, exactly two resp_valid pulses, no duplicate issue in DONE.

Source files
------------

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: single-outstanding load/store bus master that stalls the pipeline
// until the bus answers or the response timeout expires.
module dbus_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  output logic                    stall_req,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic                    bus_we,
  output logic [DATA_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_mask,
  input  logic                    bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_rsp_data,
  input  logic                    bus_rsp_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] mask_q, mask_d;
  logic                    err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = REQ;
        we_d    = req_we;
        addr_d  = req_addr & ~DATA_WIDTH'(3);
        wdata_d = req_wdata;
        mask_d  = req_mask;
      end
      REQ: state_d = bus_req_ready ? RESP : REQ;
      RESP: begin
        cnt_d = cnt_q + CW'(1);
        // a response in the timeout cycle still wins
        if (bus_rsp_valid) begin
          state_d = DONE;
          rdata_d = we_q ? '0 : bus_rsp_data;
          err_d   = bus_rsp_err;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign stall_req     = (state_q == IDLE && req_valid) || state_q == REQ || state_q == RESP;
  assign resp_valid    = state_q == DONE;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign bus_req_valid = state_q == REQ;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_mask      = mask_q;
endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: randomized bus responder with a latency/result model derived
// from the transaction rules (ready wait, response delay, timeout).
module tb_dbus_ctrl;
  localparam int DW = 32;
  localparam int T  = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [DW-1:0] req_addr = '0, req_wdata = '0;
  logic [DW/8-1:0] req_mask = '0;
  logic stall_req, resp_valid, resp_err, bus_req_valid, bus_we;
  logic [DW-1:0] resp_rdata, bus_addr, bus_wdata;
  logic [DW/8-1:0] bus_mask;
  logic bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [DW-1:0] bus_rsp_data = '0;
  int tests = 0, fails = 0, pulses = 0, handshakes = 0;

  dbus_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .stall_req(stall_req), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_mask(bus_mask), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_err(bus_rsp_err));

  always #5 clk = ~clk;

  // Model: r = REQ cycles with ready low, d = RESP cycles before the response
  // (d >= T means no response before the timeout fires).
  task automatic txn(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW/8-1:0] m, input int r, input int d,
                     input logic [DW-1:0] rd, input logic re, input bit stray);
    int w = 0, rc = 0, lat = -1, exp_lat;
    bit hs = 0, got = 0, hs_now, rsp_now;
    logic [DW-1:0] exp_rd, exp_addr;
    logic exp_err;
    exp_lat  = r + ((d < T) ? d : T - 1) + 3;
    exp_rd   = (d < T && !we) ? rd : '0;
    exp_err  = (d < T) ? re : 1'b1;
    exp_addr = {a[DW-1:2], 2'b00};
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_mask = m;
    for (int k = 0; k < 40 && !got; k++) begin
      bus_req_ready = bus_req_valid && (w == r);
      rsp_now       = hs && (rc == d);
      bus_rsp_valid = rsp_now || (!hs && stray && $urandom_range(0, 1) == 1);
      bus_rsp_data  = rsp_now ? rd : $urandom;
      bus_rsp_err   = rsp_now ? re : 1'($urandom_range(0, 1));
      #1;
      tests++;
      if (stall_req !== (k != exp_lat)) begin
        fails++; $display("FAIL stall k=%0d got=%b exp=%b", k, stall_req, k != exp_lat);
      end
      tests++;
      if (resp_valid !== (k == exp_lat)) begin
        fails++; $display("FAIL resp_valid k=%0d got=%b exp=%b", k, resp_valid, k == exp_lat);
      end
      tests++;
      if (bus_req_valid !== (k >= 1 && k <= r + 1)) begin
        fails++; $display("FAIL bus_req_valid k=%0d got=%b exp=%b", k, bus_req_valid, k >= 1 && k <= r + 1);
      end
      if (bus_req_valid) begin
        tests++;
        if ({bus_we, bus_addr, bus_wdata, bus_mask} !== {we, exp_addr, wd, m}) begin
          fails++; $display("FAIL bus_fields k=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", k,
                            bus_we, bus_addr, bus_wdata, bus_mask, we, exp_addr, wd, m);
        end
        w++;
      end
      if (resp_valid) begin
        got = 1; lat = k; pulses++;
        tests++;
        if (resp_rdata !== exp_rd || resp_err !== exp_err) begin
          fails++; $display("FAIL resp_data got=%h/%b exp=%h/%b", resp_rdata, resp_err, exp_rd, exp_err);
        end
      end
      hs_now = bus_req_valid && bus_req_ready;
      if (hs_now) handshakes++;
      @(posedge clk);
      if (hs) rc++;
      if (hs_now) hs = 1;
      @(negedge clk);
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL latency got=%0d exp=%0d", lat, exp_lat);
    end
    req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
  endtask

  task automatic idle_check(input int n, input logic [DW-1:0] rd, input logic re, input bit rsp);
    for (int k = 0; k < n; k++) begin
      bus_rsp_valid = rsp; bus_rsp_data = $urandom; bus_rsp_err = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if ({resp_valid, stall_req, bus_req_valid} !== 3'b000 || resp_rdata !== rd || resp_err !== re) begin
        fails++; $display("FAIL idle k=%0d got=%b%b%b/%h/%b exp=000/%h/%b", k, resp_valid, stall_req,
                          bus_req_valid, resp_rdata, resp_err, rd, re);
      end
      @(negedge clk);
    end
    bus_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({stall_req, resp_valid, resp_err, bus_req_valid, bus_we} !== 5'b0 ||
        {bus_addr, bus_wdata, bus_mask, resp_rdata} !== '0) begin
      fails++; $display("FAIL reset got=%b%b%b%b%b/%h/%h/%h/%h exp=all zero", stall_req, resp_valid,
                        resp_err, bus_req_valid, bus_we, bus_addr, bus_wdata, bus_mask, resp_rdata);
    end
    rst = 1'b0;
    idle_check(2, '0, 1'b0, 1'b1);
  endtask

  task automatic test_load();
    txn(1'b0, 32'h0000_1006, 32'h0, 4'b0100, 0, 0, 32'hAABB_CCDD, 1'b0, 1'b0);
    idle_check(2, 32'hAABB_CCDD, 1'b0, 1'b1);
  endtask

  task automatic test_store();
    txn(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 3, 1, 32'h5555_AAAA, 1'b0, 1'b1);
    idle_check(1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    txn(1'b0, 32'h0000_3008, 32'h0, 4'hF, 1, T + 2, 32'h1111_2222, 1'b0, 1'b0);
    idle_check(3, '0, 1'b1, 1'b1);
  endtask

  task automatic test_bus_err();
    txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_4004, 32'h0, 4'hF, 0, T - 1, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h0000_5000; req_we = 1'b0;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_check(3, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    pulses = 0; handshakes = 0;
    txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 0, 32'hCAFE_0001, 1'b0, 1'b1);
    txn(1'b0, 32'h0000_6004, 32'h0, 4'hF, 0, 0, 32'hCAFE_0002, 1'b0, 1'b1);
    idle_check(2, 32'hCAFE_0002, 1'b0, 1'b0);
    tests++;
    if (pulses !== 2 || handshakes !== 2) begin
      fails++; $display("FAIL back_to_back got=%0d/%0d exp=2/2", pulses, handshakes);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
          $urandom_range(0, T + 1), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
